// File: rtl/filter_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// filter_ctrl_pkg
//   Shared types and defaults for the filter event controller: FSM state enum
//   and default values for the controller parameters.
// ----------------------------------------------------------------------------
package filter_ctrl_pkg;
    localparam int DW_DEFAULT        = package_settings::SIZE_FILTER_DATA;
    localparam int TSW_DEFAULT       = 32;
    localparam int DEAD_TIME_DEFAULT = 64;
    localparam int MAX_WIDTH_DEFAULT = 256;
    localparam int CNTW_DEFAULT      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_TRACK,
        ST_EMIT,
        ST_DEAD
    } state_t;
endpackage

// File: rtl/package_settings.sv
// ----------------------------------------------------------------------------
// package_settings
//   Project-wide sizing shared by the filter chain. The event controller takes
//   its default sample width from SIZE_FILTER_DATA so it always matches the
//   shaping filter output.
// ----------------------------------------------------------------------------
package package_settings;
    localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/filter_event_ctrl_if.sv
// ----------------------------------------------------------------------------
// filter_event_ctrl_if
//   Event output channel of the filter event controller (valid/ready).
//   master: controller side (drives event fields and ev_valid)
//   slave : consumer side (drives ev_ready)
//   ev_valid / ev_ready : handshake
//   ev_amp   [DW]       : pulse peak, two's complement
//   ev_time  [TSW]      : timestamp of the peak sample
//   ev_trunc            : pulse ended by the width timeout
// ----------------------------------------------------------------------------
interface filter_event_ctrl_if
    import filter_ctrl_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int TSW = TSW_DEFAULT
);
    logic           ev_valid;
    logic           ev_ready;
    logic [DW-1:0]  ev_amp;
    logic [TSW-1:0] ev_time;
    logic           ev_trunc;

    modport master (output ev_valid, ev_amp, ev_time, ev_trunc, input ev_ready);
    modport slave  (input ev_valid, ev_amp, ev_time, ev_trunc, output ev_ready);
endinterface

// File: rtl/filter_sat_counter.sv
// ----------------------------------------------------------------------------
// filter_sat_counter
//   Saturating up-counter, sticks at all-ones.
//   clk, reset (async, active-low), inc (count one), clear (sync clear,
//   wins over inc), count [W] (current value).
// ----------------------------------------------------------------------------
module filter_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/filter_event_ctrl.sv
// ----------------------------------------------------------------------------
// filter_event_ctrl
//   Per-channel event controller behind the shaping filter. Arms on a signed
//   threshold crossing, tracks the pulse peak and its timestamp, emits one
//   event per pulse over a valid/ready channel, then holds off for DEAD_TIME
//   cycles. Crossings seen while an event waits or during dead time are
//   counted in lost_cnt.
// Ports
//   clk, reset      clock, async active-low reset
//   enable          1 = arm/accept pulses; 0 = finish current event, then IDLE
//   filt_data [DW]  shaped sample, signed, one per clk
//   threshold [DW]  signed trigger level, latched at pulse start
//   ev_if           event channel (master modport)
//   lost_cnt  [CNTW] saturating count of crossings ignored in EMIT/DEAD
//   pileup_cnt[CNTW] saturating count of discarded timeout pulses
//                    (only with FILTER_EVENT_PILEUP_REJECT_EN)
//   busy            state is TRACK, EMIT or DEAD
// Configuration
//   FILTER_EVENT_PILEUP_REJECT_EN: timeout pulses are dropped (TRACK -> DEAD)
//   and counted in pileup_cnt; ev_trunc stays 0. Undefined: timeout pulses are
//   emitted with ev_trunc=1.
// ----------------------------------------------------------------------------
module filter_event_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int TSW       = TSW_DEFAULT,
    parameter int DEAD_TIME = DEAD_TIME_DEFAULT,
    parameter int MAX_WIDTH = MAX_WIDTH_DEFAULT,
    parameter int CNTW      = CNTW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic signed [DW-1:0] filt_data,
    input  logic signed [DW-1:0] threshold,
    filter_event_ctrl_if.master  ev_if,
    output logic [CNTW-1:0]      lost_cnt,
`ifdef FILTER_EVENT_PILEUP_REJECT_EN
    output logic [CNTW-1:0]      pileup_cnt,
`endif
    output logic                 busy
);
    localparam int WCW = $clog2(MAX_WIDTH + 1);
    localparam int DCW = $clog2(DEAD_TIME + 1);

    // Peak tracker doubles as the outgoing event: it is frozen once TRACK ends.
    typedef struct packed {
        logic signed [DW-1:0] amp;
        logic [TSW-1:0]       ts;
        logic                 trunc;
    } event_t;

    state_t               state_q, state_d;
    event_t               ev_q, ev_d;
    logic signed [DW-1:0] thr_q, thr_d;
    logic signed [DW-1:0] prev_q;
    logic [TSW-1:0]       ts_q;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic [DCW-1:0]       dcnt_q, dcnt_d;
    logic                 timeout;
    logic                 lost_inc;
`ifdef FILTER_EVENT_PILEUP_REJECT_EN
    logic                 pileup_inc;
`endif

    assign timeout = (wcnt_q == WCW'(MAX_WIDTH));

    // Rising crossing against the live threshold, only counted while an event
    // is pending or during hold-off.
    assign lost_inc = ((state_q == ST_EMIT) || (state_q == ST_DEAD)) &&
                      (prev_q <= threshold) && (filt_data > threshold);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ev_d    = ev_q;
        thr_d   = thr_q;
        wcnt_d  = wcnt_q;
        dcnt_d  = dcnt_q;
`ifdef FILTER_EVENT_PILEUP_REJECT_EN
        pileup_inc = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (filt_data > threshold) begin
                    state_d  = ST_TRACK;
                    thr_d    = threshold;
                    ev_d.amp = filt_data;
                    ev_d.ts  = ts_q;
                    ev_d.trunc = 1'b0;
                    wcnt_d   = WCW'(1);
                end
            end
            ST_TRACK: begin
                if (filt_data <= thr_q) begin
                    state_d    = ST_EMIT;
                    ev_d.trunc = 1'b0;
                end else begin
                    // Strict compare: equal samples keep the earliest timestamp.
                    if (filt_data > $signed(ev_q.amp)) begin
                        ev_d.amp = filt_data;
                        ev_d.ts  = ts_q;
                    end
                    if (timeout) begin
`ifdef FILTER_EVENT_PILEUP_REJECT_EN
                        state_d    = ST_DEAD;
                        dcnt_d     = DCW'(DEAD_TIME - 1);
                        pileup_inc = 1'b1;
`else
                        state_d    = ST_EMIT;
                        ev_d.trunc = 1'b1;
`endif
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (ev_if.ev_ready) begin
                    state_d = ST_DEAD;
                    dcnt_d  = DCW'(DEAD_TIME - 1);
                end
            end
            ST_DEAD: begin
                if (dcnt_q == '0) state_d = enable ? ST_ARMED : ST_IDLE;
                else              dcnt_d  = dcnt_q - DCW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ev_q    <= '0;
            thr_q   <= '0;
            prev_q  <= '0;
            ts_q    <= '0;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
            thr_q   <= thr_d;
            prev_q  <= filt_data;
            ts_q    <= ts_q + TSW'(1);
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    filter_sat_counter #(.W(CNTW)) u_lost_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lost_inc),
        .clear (1'b0),
        .count (lost_cnt)
    );

`ifdef FILTER_EVENT_PILEUP_REJECT_EN
    filter_sat_counter #(.W(CNTW)) u_pileup_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pileup_inc),
        .clear (1'b0),
        .count (pileup_cnt)
    );
`endif

    assign ev_if.ev_valid = (state_q == ST_EMIT);
    assign ev_if.ev_amp   = ev_q.amp;
    assign ev_if.ev_time  = ev_q.ts;
    assign ev_if.ev_trunc = ev_q.trunc;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_ARMED);
endmodule

// File: tb/tb_filter_event_ctrl.sv
// ----------------------------------------------------------------------------
// tb_filter_event_ctrl
//   Directed scenarios followed by random traffic for filter_event_ctrl,
//   checked every cycle against a behavioural pulse/event model.
//   Small parameters: TSW=4, MAX_WIDTH=8, CNTW=2 exercise wrap, timeout and
//   saturation quickly. Honours FILTER_EVENT_PILEUP_REJECT_EN.
// ----------------------------------------------------------------------------
module tb_filter_event_ctrl;
    localparam int DW        = 16;
    localparam int TSW       = 4;
    localparam int DEAD_TIME = 64;
    localparam int MAX_WIDTH = 8;
    localparam int CNTW      = 2;
    localparam int TS_MOD    = 1 << TSW;
    localparam int CNT_MAX   = (1 << CNTW) - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic signed [DW-1:0] filt_data = '0;
    logic signed [DW-1:0] threshold = '0;
    logic [CNTW-1:0]      lost_cnt;
    logic                 busy;
`ifdef FILTER_EVENT_PILEUP_REJECT_EN
    logic [CNTW-1:0]      pileup_cnt;
`endif

    filter_event_ctrl_if #(.DW(DW), .TSW(TSW)) ev_if ();

    filter_event_ctrl #(
        .DW(DW), .TSW(TSW), .DEAD_TIME(DEAD_TIME), .MAX_WIDTH(MAX_WIDTH), .CNTW(CNTW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .filt_data (filt_data),
        .threshold (threshold),
        .ev_if     (ev_if),
        .lost_cnt  (lost_cnt),
`ifdef FILTER_EVENT_PILEUP_REJECT_EN
        .pileup_cnt(pileup_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: a pulse is the run of samples above the threshold
    // latched at its first sample; it yields one event unless the channel is
    // not listening (event pending, hold-off, disabled).
    int  m_ts, m_prev, m_thr, m_len, m_dead, m_lost, m_pile;
    int  m_amp, m_time;
    bit  m_listen, m_pulse, m_event, m_trunc;

    function automatic void model_reset();
        m_ts = 0; m_prev = 0; m_thr = 0; m_len = 0; m_dead = 0;
        m_lost = 0; m_pile = 0; m_amp = 0; m_time = 0;
        m_listen = 0; m_pulse = 0; m_event = 0; m_trunc = 0;
    endfunction

    function automatic bit model_busy();
        return m_pulse || m_event || (m_dead > 0);
    endfunction

    function automatic void model_step(input bit en, input int d, input int thr, input bit rdy);
        if ((m_event || m_dead > 0) && m_prev <= thr && d > thr && m_lost < CNT_MAX)
            m_lost++;
        if (m_event) begin
            if (rdy) begin
                m_event = 0;
                m_dead  = DEAD_TIME;
            end
        end else if (m_dead > 0) begin
            m_dead--;
            if (m_dead == 0) m_listen = en;
        end else if (m_pulse) begin
            m_len++;
            if (d <= m_thr) begin
                m_pulse = 0; m_event = 1; m_trunc = 0;
            end else begin
                if (d > m_amp) begin m_amp = d; m_time = m_ts; end
                if (m_len > MAX_WIDTH) begin
                    m_pulse = 0;
`ifdef FILTER_EVENT_PILEUP_REJECT_EN
                    m_dead = DEAD_TIME;
                    if (m_pile < CNT_MAX) m_pile++;
`else
                    m_event = 1; m_trunc = 1;
`endif
                end
            end
        end else if (m_listen) begin
            if (!en) m_listen = 0;
            else if (d > thr) begin
                m_listen = 0; m_pulse = 1; m_thr = thr;
                m_amp = d; m_time = m_ts; m_len = 1;
            end
        end else if (en) begin
            m_listen = 1;
        end
        m_prev = d;
        m_ts   = (m_ts + 1) % TS_MOD;
    endfunction

    task automatic compare_all();
        check("ev_valid", 32'(ev_if.ev_valid), 32'(m_event));
        check("busy", 32'(busy), 32'(model_busy()));
        check("lost_cnt", 32'(lost_cnt), 32'(m_lost));
`ifdef FILTER_EVENT_PILEUP_REJECT_EN
        check("pileup_cnt", 32'(pileup_cnt), 32'(m_pile));
`endif
        if (m_event) begin
            check("ev_amp", 32'(ev_if.ev_amp), 32'(m_amp & 32'hFFFF));
            check("ev_time", 32'(ev_if.ev_time), 32'(m_time));
            check("ev_trunc", 32'(ev_if.ev_trunc), 32'(m_trunc));
        end
    endtask

    task automatic step(input bit en, input int d, input int thr, input bit rdy);
        enable         = en;
        filt_data      = DW'(d);
        threshold      = DW'(thr);
        ev_if.ev_ready = rdy;
        @(posedge clk);
        model_step(en, d, thr, rdy);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(ev_if.ev_valid), 32'd0);
        check({tag, "_amp"},   32'(ev_if.ev_amp),   32'd0);
        check({tag, "_time"},  32'(ev_if.ev_time),  32'd0);
        check({tag, "_trunc"}, 32'(ev_if.ev_trunc), 32'd0);
        check({tag, "_lost"},  32'(lost_cnt),       32'd0);
        check({tag, "_busy"},  32'(busy),           32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t300;
        int d, thr, burst;
        bit en, rdy;

        ev_if.ev_ready = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset_init");
        @(negedge clk);
        reset = 1'b1;

        // Basic pulse: peak 300, event one cycle after the 90 sample.
        step(1, 0, 100, 0);
        step(1, 0, 100, 0);
        step(1, 50, 100, 0);
        step(1, 150, 100, 0);
        t300 = m_ts;
        step(1, 300, 100, 0);
        step(1, 280, 100, 0);
        check("pre_latency_valid", 32'(ev_if.ev_valid), 32'd0);
        step(1, 90, 100, 0);
        check("ev2_valid", 32'(ev_if.ev_valid), 32'd1);
        check("ev2_amp",   32'(ev_if.ev_amp),   32'd300);
        check("ev2_time",  32'(ev_if.ev_time),  32'(t300));
        check("ev2_trunc", 32'(ev_if.ev_trunc), 32'd0);

        // Stalled consumer; a second pulse during EMIT is lost.
        for (int i = 0; i < 20; i++) begin
            step(1, (i == 5) ? 200 : 0, 100, 0);
            check("stall_amp", 32'(ev_if.ev_amp), 32'd300);
        end
        check("lost_one", 32'(lost_cnt), 32'd1);
        step(1, 0, 100, 1);
        for (int i = 0; i < DEAD_TIME; i++) step(1, 0, 100, 0);
        check("dead_done", 32'(busy), 32'd0);

        // Held level above threshold: width timeout.
        step(1, 500, 100, 0);
        check("armed_after_dead", 32'(busy), 32'd1);
        for (int i = 0; i < MAX_WIDTH; i++) step(1, 500, 100, 0);
`ifdef FILTER_EVENT_PILEUP_REJECT_EN
        check("pileup_valid", 32'(ev_if.ev_valid), 32'd0);
        check("pileup_one", 32'(pileup_cnt), 32'd1);
`else
        check("trunc_valid", 32'(ev_if.ev_valid), 32'd1);
        check("trunc_flag", 32'(ev_if.ev_trunc), 32'd1);
        check("trunc_amp", 32'(ev_if.ev_amp), 32'd500);
`endif

        // Five more lost crossings saturate the 2-bit counter.
        for (int i = 0; i < 10; i++) step(1, (i % 2 == 1) ? 200 : 0, 100, 0);
        check("lost_sat", 32'(lost_cnt), 32'(CNT_MAX));
        step(1, 0, 100, 1);
        for (int k = 0; k < 200 && (busy || model_busy()); k++) step(1, 0, 100, 0);
        check("dead_exit", 32'(busy), 32'd0);

        // Peak on the timestamp wrap; enable drops mid-pulse.
        for (int k = 0; k < 40 && m_ts != 14; k++) step(1, 0, 100, 0);
        step(1, 150, 100, 0);
        step(1, 200, 100, 0);
        step(1, 400, 100, 0);
        step(0, 300, 100, 0);
        step(0, 50, 100, 0);
        check("wrap_valid", 32'(ev_if.ev_valid), 32'd1);
        check("wrap_time",  32'(ev_if.ev_time),  32'd0);
        check("wrap_amp",   32'(ev_if.ev_amp),   32'd400);
        step(0, 0, 100, 1);
        for (int i = 0; i < DEAD_TIME; i++) step(0, 0, 100, 0);
        step(0, 500, 100, 0);
        check("idle_no_arm", 32'(busy), 32'd0);

        // Asynchronous reset while an event is stalled.
        step(1, 0, 100, 0);
        step(1, 0, 100, 0);
        step(1, 200, 100, 0);
        step(1, 50, 100, 0);
        check("pre_reset_valid", 32'(ev_if.ev_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("reset_emit");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 100, 0);
        step(1, 0, 100, 0);

        // Random traffic.
        thr = 100;
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) thr = int'($urandom_range(0, 400)) - 100;
            if (burst > 0) begin
                d = thr + 1 + int'($urandom_range(0, 300));
                burst--;
            end else begin
                if ($urandom_range(0, 99) == 0) burst = 12;
                d = int'($urandom_range(0, 900)) - 300;
            end
            en  = ($urandom_range(0, 31) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            step(en, d, thr, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
